// File: rtl/serial_magnitude_comparator_pkg.sv
// Shared types for the digit-serial magnitude comparator: FSM state and the
// one-hot {gt, eq, lt} result encoding.
package cmp_pkg;

    typedef enum logic [1:0] {IDLE, SCAN, DONE} cmp_state_t;

    typedef struct packed {
        logic gt;
        logic eq;
        logic lt;
    } cmp_result_t;

    localparam cmp_result_t CMP_GT   = '{gt: 1'b1, eq: 1'b0, lt: 1'b0};
    localparam cmp_result_t CMP_EQ   = '{gt: 1'b0, eq: 1'b1, lt: 1'b0};
    localparam cmp_result_t CMP_LT   = '{gt: 1'b0, eq: 1'b0, lt: 1'b1};
    localparam cmp_result_t CMP_NONE = '{gt: 1'b0, eq: 1'b0, lt: 1'b0};

endpackage

// File: rtl/serial_magnitude_comparator_if.sv
// Operand-in / result-out handshake bundle of the serial magnitude comparator.
interface serial_magnitude_comparator_if #(
    parameter int WIDTH   = 16,
    parameter int DIGIT_W = 2
);
    localparam int NUM_DIGITS = WIDTH / DIGIT_W;
    localparam int CNT_W      = $clog2(NUM_DIGITS + 1);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic             gt;
    logic             eq;
    logic             lt;
    logic [CNT_W-1:0] digits_used;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, gt, eq, lt, digits_used
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, gt, eq, lt, digits_used
    );

endinterface

// File: rtl/serial_magnitude_comparator_digit_compare.sv
// Combinational unsigned compare of one DIGIT_W-bit digit pair.
module digit_compare #(
    parameter int DIGIT_W = 2
) (
    input  logic [DIGIT_W-1:0] x,
    input  logic [DIGIT_W-1:0] y,
    output logic               gt,
    output logic               lt
);

    assign gt = (x > y);
    assign lt = (x < y);

endmodule

// File: rtl/serial_magnitude_comparator.sv
// Digit-serial unsigned magnitude comparator: scans MSB-first, DIGIT_W bits per
// cycle, and stops at the first differing digit.
//
// state | meaning
// IDLE  | ready for an operand pair
// SCAN  | comparing the top digits of the shift registers
// DONE  | result held until out_ready
module serial_magnitude_comparator
    import cmp_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int DIGIT_W = 2
) (
    input logic                         clk,
    input logic                         rst_n,
    serial_magnitude_comparator_if.slave bus
);

    localparam int NUM_DIGITS = WIDTH / DIGIT_W;
    localparam int CNT_W      = $clog2(NUM_DIGITS + 1);

    cmp_state_t       state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [CNT_W-1:0] cnt;
    cmp_result_t      res;
    logic [CNT_W-1:0] digits_used;
    logic             dig_gt;
    logic             dig_lt;

    digit_compare #(.DIGIT_W(DIGIT_W)) u_digit_compare (
        .x  (a_sh[WIDTH-1 -: DIGIT_W]),
        .y  (b_sh[WIDTH-1 -: DIGIT_W]),
        .gt (dig_gt),
        .lt (dig_lt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            a_sh        <= '0;
            b_sh        <= '0;
            cnt         <= '0;
            res         <= CMP_NONE;
            digits_used <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_sh  <= bus.a;
                        b_sh  <= bus.b;
                        cnt   <= '0;
                        state <= SCAN;
                    end
                end
                SCAN: begin
                    if (dig_gt) begin
                        res         <= CMP_GT;
                        digits_used <= cnt + CNT_W'(1);
                        state       <= DONE;
                    end else if (dig_lt) begin
                        res         <= CMP_LT;
                        digits_used <= cnt + CNT_W'(1);
                        state       <= DONE;
                    end else if (cnt == CNT_W'(NUM_DIGITS - 1)) begin
                        res         <= CMP_EQ;
                        digits_used <= CNT_W'(NUM_DIGITS);
                        state       <= DONE;
                    end else begin
                        a_sh <= a_sh << DIGIT_W;
                        b_sh <= b_sh << DIGIT_W;
                        cnt  <= cnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    // Flags keep their last values after the handshake.
                    if (bus.out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready    = (state == IDLE);
    assign bus.out_valid   = (state == DONE);
    assign bus.gt          = res.gt;
    assign bus.eq          = res.eq;
    assign bus.lt          = res.lt;
    assign bus.digits_used = digits_used;

endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// Directed, table-driven bench for serial_magnitude_comparator (WIDTH=16, DIGIT_W=2).
module tb_serial_magnitude_comparator;

    localparam int WIDTH   = 16;
    localparam int DIGIT_W = 2;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [2:0]  flags;   // {gt, eq, lt}
        int          digits;  // expected digits_used == expected latency
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_fail = 0;

    serial_magnitude_comparator_if #(.WIDTH(WIDTH), .DIGIT_W(DIGIT_W)) bus ();

    serial_magnitude_comparator #(.WIDTH(WIDTH), .DIGIT_W(DIGIT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int flags();
        return int'({bus.gt, bus.eq, bus.lt});
    endfunction

    // Accept one pair, wait for the result, check it, leave it pending (out_ready=0).
    task automatic start_and_wait(input logic [15:0] a, input logic [15:0] b, output int lat);
        int guard = 0;
        while (!bus.in_ready && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        check("in_ready_before_accept", int'(bus.in_ready), 1);
        bus.a = a;
        bus.b = b;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        lat = 0;
        while (!bus.out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check("out_valid_seen", int'(bus.out_valid), 1);
    endtask

    task automatic handshake();
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        check("out_valid_after_hs", int'(bus.out_valid), 0);
        check("in_ready_after_hs", int'(bus.in_ready), 1);
    endtask

    vec_t vecs[10];

    initial begin
        int lat;

        vecs[0] = '{16'h8000, 16'h7FFF, 3'b100, 1};
        vecs[1] = '{16'h1234, 16'h1234, 3'b010, 8};
        vecs[2] = '{16'h1233, 16'h1234, 3'b001, 7};
        vecs[3] = '{16'h0000, 16'h0000, 3'b010, 8};
        vecs[4] = '{16'hFFFF, 16'h0000, 3'b100, 1};
        vecs[5] = '{16'h0000, 16'hFFFF, 3'b001, 1};
        vecs[6] = '{16'h0001, 16'h0000, 3'b100, 8};
        vecs[7] = '{16'h4000, 16'h8000, 3'b001, 1};
        vecs[8] = '{16'h0C00, 16'h0800, 3'b100, 3};
        vecs[9] = '{16'h0030, 16'h0020, 3'b100, 6};

        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.a         = '0;
        bus.b         = '0;

        #12;
        check("rst_in_ready", int'(bus.in_ready), 1);
        check("rst_out_valid", int'(bus.out_valid), 0);
        check("rst_flags", flags(), 0);
        check("rst_digits_used", int'(bus.digits_used), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 10; i++) begin
            start_and_wait(vecs[i].a, vecs[i].b, lat);
            check($sformatf("vec%0d_flags", i), flags(), int'(vecs[i].flags));
            check($sformatf("vec%0d_digits_used", i), int'(bus.digits_used), vecs[i].digits);
            check($sformatf("vec%0d_latency", i), lat, vecs[i].digits);
            check($sformatf("vec%0d_in_ready_done", i), int'(bus.in_ready), 0);
            handshake();
        end

        // Result held under back-pressure; a stray in_valid pulse must be ignored.
        start_and_wait(16'h0001, 16'h0000, lat);
        for (int c = 0; c < 5; c++) begin
            if (c == 2) begin
                bus.a = 16'h0000;
                bus.b = 16'hFFFF;
                bus.in_valid = 1'b1;
            end
            @(posedge clk); #1;
            bus.in_valid = 1'b0;
            check("hold_out_valid", int'(bus.out_valid), 1);
            check("hold_flags", flags(), 3'b100);
            check("hold_digits_used", int'(bus.digits_used), 8);
            check("hold_in_ready", int'(bus.in_ready), 0);
        end
        handshake();
        @(posedge clk); #1;
        check("hold_no_stray_accept", int'(bus.in_ready), 1);

        // Back-to-back with out_ready tied high and in_valid held.
        bus.out_ready = 1'b1;
        bus.a = 16'h0000;
        bus.b = 16'hFFFF;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        check("b2b_scan1", int'(bus.in_ready), 0);
        @(posedge clk); #1;
        check("b2b_res1_valid", int'(bus.out_valid), 1);
        check("b2b_res1_flags", flags(), 3'b001);
        check("b2b_res1_digits", int'(bus.digits_used), 1);
        bus.a = 16'hFFFF;
        bus.b = 16'h0000;
        @(posedge clk); #1;
        check("b2b_idle_valid", int'(bus.out_valid), 0);
        check("b2b_idle_ready", int'(bus.in_ready), 1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        check("b2b_accept2", int'(bus.in_ready), 0);
        check("b2b_accept2_valid", int'(bus.out_valid), 0);
        @(posedge clk); #1;
        check("b2b_res2_valid", int'(bus.out_valid), 1);
        check("b2b_res2_flags", flags(), 3'b100);
        check("b2b_res2_digits", int'(bus.digits_used), 1);
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        check("b2b_end_ready", int'(bus.in_ready), 1);

        // Asynchronous reset in the middle of a scan.
        bus.a = 16'h1234;
        bus.b = 16'h1235;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid_out_valid", int'(bus.out_valid), 0);
        check("rst_mid_in_ready", int'(bus.in_ready), 1);
        check("rst_mid_flags", flags(), 0);
        check("rst_mid_digits", int'(bus.digits_used), 0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        start_and_wait(16'h0005, 16'h0005, lat);
        check("post_rst_flags", flags(), 3'b010);
        check("post_rst_digits", int'(bus.digits_used), 8);
        check("post_rst_latency", lat, 8);
        handshake();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
